uart_line_status: RTL and testbench
===================================

# uart_line_status

Receive/transmit line-status tracker for the UART. It maintains the 8-bit Line Status Register (LSR), including a per-character error-flag shadow FIFO that mirrors the RX data FIFO. It drives the status inputs of the interrupt generator: `dr`, `thre`, `pe`, `fe`, `bi` and `below_level`. It sits between the receiver / RX-TX FIFOs and the interrupt generator and host register file.

## Interface

Parameters:
- `FIFO_DEPTH`, default 16: RX/TX FIFO depth; must be 16 for the trigger-level map.
- `CNT_W`, default $clog2(FIFO_DEPTH)+1: occupancy count width.

Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-high reset.

Inputs:
- `rx_push` in 1: receiver writes one character to the RX FIFO this cycle.
- `rx_pe`, `rx_fe`, `rx_bi` in 1 each: error flags of the character pushed with `rx_push`.
- `rx_pop` in 1: host reads RBR; pops the RX FIFO head.
- `rx_count` in CNT_W: RX FIFO occupancy, registered in the FIFO.
- `tx_count` in CNT_W: TX FIFO occupancy.
- `tx_shift_empty` in 1: transmit shift register idle.
- `lsr_rd` in 1: host read strobe of the LSR, one cycle.
- `fifo_en` in 1: FCR[0].
- `rx_trig` in 2: FCR[7:6] RX trigger select.
- `rx_fifo_clr` in 1: FCR RX FIFO reset pulse.

Outputs:
- `lsr` out 8: {err_in_fifo, temt, thre, bi, fe, pe, oe, dr}.
- `dr`, `thre`, `pe`, `fe`, `bi`, `below_level` out 1 each: to the interrupt generator.

## Operation

- **Effective depth** = FIFO_DEPTH when `fifo_en`=1, else 1.
- **Flag FIFO:**
  - 3 bits {pe,fe,bi} per entry, FIFO_DEPTH entries, with its own read/write pointers and count.
  - Written on an accepted `rx_push`; popped on `rx_pop` when non-empty.
  - Cleared (pointers, count and error counter) on `rx_fifo_clr`.
  - Pointers wrap modulo FIFO_DEPTH.
- **Accepted push:** `rx_push` and (`rx_count` < effective depth, or `rx_pop`).
- **Overrun:** `rx_push` when full and no `rx_pop`.
  - Sets sticky `oe`; the character and its flags are dropped.
- **Head flags:** `head_valid` = flag FIFO non-empty.
  - Sticky `pe`/`fe`/`bi` set when `head_valid` and the head bit = 1 and `lsr_rd`=0.
- **`lsr_rd`:**
  - Clears `oe`, `pe`, `fe` and `bi`.
  - Zeroes the head entry's flag bits, so the same character never re-sets them.
  - If `rx_pop` occurs in the same cycle, the popped entry is discarded and the new head is untouched.
- **`err_cnt`:** number of flag-FIFO entries with any flag set.
  - +1 on an accepted push with any flag.
  - −1 when an errored head is popped, or when its flags are zeroed by `lsr_rd`.
  - Saturation never occurs (bounded by depth).
  - lsr[7] = (`err_cnt` != 0) & `fifo_en`.
- **Combinational status:**
  - `dr` = (`rx_count` != 0).
  - `thre` = (`tx_count` == 0).
  - `temt` = `thre` & `tx_shift_empty`.
- **below_level:** `fifo_en` & (`rx_count` < trig), where trig maps 0→1, 1→4, 2→8, 3→14. Forced 0 when `fifo_en`=0.
- **`rx_fifo_clr`:** does not clear sticky bits; only `lsr_rd` or `rst` does.
- **Simultaneous events:** a new set event (overrun, new head flag) in the cycle after `lsr_rd` is recorded normally. Overrun occurring in the `lsr_rd` cycle itself is set (set wins for `oe`).

## Timing

- **Reset values:**
  - `oe`, `pe`, `fe`, `bi`, lsr[7], flag-FIFO count and `err_cnt` = 0.
  - `dr` = 0, `thre` = 1, `temt` = `tx_shift_empty`, `below_level` = `fifo_en` (count 0 < trig).
- **Sticky bit latency:** registered; visible 1 cycle after the triggering push/head condition.
  - A push into an empty FIFO with `rx_pe`=1 → `pe`=1 on cycle N+2 (flag FIFO write at N+1, sticky set at N+2).
- **`lsr_rd` clear:** takes effect the next cycle. The LSR value presented during the `lsr_rd` cycle is the pre-clear value.
- **Combinational outputs:** `dr`, `thre`, `temt` and `below_level` have 0-cycle latency from the count inputs.
- **`rx_fifo_clr`:** flag-FIFO state empty on the next cycle; it takes priority over a same-cycle push/pop.

## Test plan

- **Reset, idle:** `rst` 1 cycle, counts 0, `tx_shift_empty`=1 → `lsr`=8'h60, `below_level`=`fifo_en`.
- **Parity error, clear on read:** push with `rx_pe`=1 into an empty FIFO (`fifo_en`=1) → `pe`=1 and lsr[7]=1 two cycles later; `lsr_rd` → `pe`=0 next cycle, lsr[7]=0; no re-set while the character stays at the head.
- **Errored character not at head:** push a clean character then an `rx_fe` character; `pe`/`fe`=0 until the first `rx_pop`; then `fe`=1.
- **Overrun, FIFO mode:** `rx_count`=16, `rx_push`, no pop → `oe`=1, flag-FIFO count stays 16, `err_cnt` unchanged. Same with `rx_pop` asserted → no overrun.
- **Overrun, non-FIFO mode:** `fifo_en`=0, `rx_count`=1, `rx_push` → `oe`=1, `below_level`=0.
- **Trigger thresholds:** `rx_trig`=2; `rx_count` 7 → `below_level`=1; `rx_count` 8 → 0. `rx_trig`=3 with `rx_count`=13/14 → 1/0.

Source files
------------

// File: rtl/uart_line_status.sv
// uart_line_status: UART Line Status Register tracker.
// Keeps sticky RX error bits, a per-character {pe,fe,bi} shadow FIFO that
// follows the RX data FIFO, and the status lines for the interrupt generator.
module uart_line_status #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_push,
  input  logic             rx_pe,
  input  logic             rx_fe,
  input  logic             rx_bi,
  input  logic             rx_pop,
  input  logic [CNT_W-1:0] rx_count,
  input  logic [CNT_W-1:0] tx_count,
  input  logic             tx_shift_empty,
  input  logic             lsr_rd,
  input  logic             fifo_en,
  input  logic [1:0]       rx_trig,
  input  logic             rx_fifo_clr,
  output logic [7:0]       lsr,
  output logic             dr,
  output logic             thre,
  output logic             pe,
  output logic             fe,
  output logic             bi,
  output logic             below_level
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  // Shadow flag FIFO state, entry layout {pe,fe,bi}
  logic [2:0]       flag_mem_q [FIFO_DEPTH];
  logic [2:0]       flag_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Sticky LSR bits
  logic oe_q, oe_d;
  logic pe_q, pe_d;
  logic fe_q, fe_d;
  logic bi_q, bi_d;

  logic [CNT_W-1:0] eff_depth;
  logic [CNT_W-1:0] trig_lvl;
  logic             room;
  logic             push_ok;
  logic             overrun;
  logic             head_valid;
  logic [2:0]       head_flags;
  logic             pop_ok;
  logic             zero_head;
  logic [2:0]       new_flags;
  logic             temt;

  // Push/pop qualification and head-of-FIFO view
  always_comb begin
    eff_depth  = fifo_en ? CNT_W'(FIFO_DEPTH) : CNT_W'(1);
    room       = rx_count < eff_depth;
    push_ok    = rx_push & (room | rx_pop);
    overrun    = rx_push & ~room & ~rx_pop;
    head_valid = fcnt_q != '0;
    head_flags = flag_mem_q[rd_ptr_q];
    pop_ok     = rx_pop & head_valid;
    // A popped head is discarded, so only zero it when it stays at the head
    zero_head  = lsr_rd & head_valid & ~rx_pop;
    new_flags  = {rx_pe, rx_fe, rx_bi};
  end

  // Flag FIFO next state; a FIFO clear overrides same-cycle push/pop
  always_comb begin
    flag_mem_d = flag_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fcnt_d     = fcnt_q;
    err_cnt_d  = err_cnt_q;
    if (rx_fifo_clr) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      fcnt_d    = '0;
      err_cnt_d = '0;
    end else begin
      if (zero_head) flag_mem_d[rd_ptr_q] = 3'b000;
      if (pop_ok) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      if (push_ok) begin
        flag_mem_d[wr_ptr_q] = new_flags;
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      fcnt_d    = fcnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      // Errored entries leave the count either by popping or by being zeroed
      err_cnt_d = err_cnt_q + CNT_W'(push_ok & (|new_flags))
                            - CNT_W'((pop_ok | zero_head) & (|head_flags));
    end
  end

  // Sticky bits: a read clears them; overrun still sets during the read cycle
  always_comb begin
    oe_d = (oe_q & ~lsr_rd) | overrun;
    pe_d = ~lsr_rd & (pe_q | (head_valid & head_flags[2]));
    fe_d = ~lsr_rd & (fe_q | (head_valid & head_flags[1]));
    bi_d = ~lsr_rd & (bi_q | (head_valid & head_flags[0]));
  end

  // RX trigger level map for the below-threshold indication
  always_comb begin
    case (rx_trig)
      2'd0:    trig_lvl = CNT_W'(1);
      2'd1:    trig_lvl = CNT_W'(4);
      2'd2:    trig_lvl = CNT_W'(8);
      default: trig_lvl = CNT_W'(14);
    endcase
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fcnt_q    <= '0;
      err_cnt_q <= '0;
      oe_q      <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      bi_q      <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fcnt_q    <= fcnt_d;
      err_cnt_q <= err_cnt_d;
      oe_q      <= oe_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      bi_q      <= bi_d;
    end
  end

  // Flag storage needs no reset: entries are only read while counted valid
  always_ff @(posedge clk) begin
    flag_mem_q <= flag_mem_d;
  end

  assign dr          = rx_count != '0;
  assign thre        = tx_count == '0;
  assign temt        = thre & tx_shift_empty;
  assign below_level = fifo_en & (rx_count < trig_lvl);
  assign pe          = pe_q;
  assign fe          = fe_q;
  assign bi          = bi_q;
  assign lsr         = {(err_cnt_q != '0) & fifo_en, temt, thre, bi_q, fe_q, pe_q, oe_q, dr};

endmodule

// File: tb/tb_uart_line_status.sv
// Bench for uart_line_status: directed scenarios then random traffic, all
// compared against a queue-based model of the RX characters and sticky bits.
module tb_uart_line_status;
  localparam int CNT_W = 5;

  logic clk = 1'b0;
  logic rst, rx_push, rx_pe, rx_fe, rx_bi, rx_pop, tx_shift_empty, lsr_rd, fifo_en, rx_fifo_clr;
  logic [CNT_W-1:0] rx_count, tx_count;
  logic [1:0] rx_trig;
  logic [7:0] lsr;
  logic dr, thre, pe, fe, bi, below_level;

  int checks = 0;
  int errors = 0;

  // model state
  logic [2:0] q[$];
  bit m_oe, m_pe, m_fe, m_bi;
  bit ovr_mode = 0;

  uart_line_status dut (
    .clk(clk), .rst(rst), .rx_push(rx_push), .rx_pe(rx_pe), .rx_fe(rx_fe), .rx_bi(rx_bi),
    .rx_pop(rx_pop), .rx_count(rx_count), .tx_count(tx_count), .tx_shift_empty(tx_shift_empty),
    .lsr_rd(lsr_rd), .fifo_en(fifo_en), .rx_trig(rx_trig), .rx_fifo_clr(rx_fifo_clr),
    .lsr(lsr), .dr(dr), .thre(thre), .pe(pe), .fe(fe), .bi(bi), .below_level(below_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int trig_of(input logic [1:0] t);
    case (t)
      2'd0: return 1;
      2'd1: return 4;
      2'd2: return 8;
      default: return 14;
    endcase
  endfunction

  function automatic int model_errs();
    int n = 0;
    foreach (q[i]) if (q[i] != 3'b000) n++;
    return n;
  endfunction

  function automatic logic [7:0] exp_lsr();
    int  t   = int'(tx_count);
    int  r   = int'(rx_count);
    bit  em  = (t == 0);
    return {(model_errs() > 0) && fifo_en, em && tx_shift_empty, em,
            m_bi, m_fe, m_pe, m_oe, r > 0};
  endfunction

  task automatic check_outputs();
    logic [7:0] e = exp_lsr();
    bit bl = fifo_en && (int'(rx_count) < trig_of(rx_trig));
    chk("lsr", lsr, e);
    chk("below_level", {7'b0, below_level}, {7'b0, bl});
    chk("irq_lines", {3'b0, dr, thre, pe, fe, bi}, {3'b0, e[0], e[5], e[2], e[3], e[4]});
  endtask

  // Apply the behavioural rules to one clock edge using the inputs held during it
  task automatic model_update();
    bit hv, ovr, acc;
    logic [2:0] h;
    int eff, r;
    if (rst) begin
      q.delete(); m_oe = 0; m_pe = 0; m_fe = 0; m_bi = 0;
      return;
    end
    hv  = q.size() > 0;
    h   = hv ? q[0] : 3'b000;
    eff = fifo_en ? 16 : 1;
    r   = int'(rx_count);
    ovr = rx_push && r >= eff && !rx_pop;
    acc = rx_push && (r < eff || rx_pop);
    m_oe = ovr || (m_oe && !lsr_rd);
    if (lsr_rd) begin
      m_pe = 0; m_fe = 0; m_bi = 0;
    end else begin
      m_pe = m_pe || (hv && h[2]);
      m_fe = m_fe || (hv && h[1]);
      m_bi = m_bi || (hv && h[0]);
    end
    if (rx_fifo_clr) q.delete();
    else begin
      if (lsr_rd && hv && !rx_pop) q[0] = 3'b000;
      if (rx_pop && hv) void'(q.pop_front());
      if (acc) q.push_back({rx_pe, rx_fe, rx_bi});
    end
  endtask

  task automatic step();
    #1 check_outputs();
    @(posedge clk);
    model_update();
    #1;
    rx_push = 0; rx_pe = 0; rx_fe = 0; rx_bi = 0; rx_pop = 0; lsr_rd = 0; rx_fifo_clr = 0; rst = 0;
    if (!ovr_mode) rx_count = CNT_W'(q.size());
    @(negedge clk);
  endtask

  initial begin
    int e0;
    rst = 1; rx_push = 0; rx_pe = 0; rx_fe = 0; rx_bi = 0; rx_pop = 0; lsr_rd = 0;
    rx_fifo_clr = 0; rx_count = 0; tx_count = 0; tx_shift_empty = 1; fifo_en = 1; rx_trig = 0;
    @(negedge clk);
    @(posedge clk); model_update(); #1 rst = 0;
    @(negedge clk);

    // reset / idle
    chk("reset_lsr", lsr, 8'h60);
    chk("reset_below", {7'b0, below_level}, 8'h01);
    fifo_en = 0; #1 chk("reset_below_nofifo", {7'b0, below_level}, 8'h00);
    fifo_en = 1;

    // parity error, cleared by read, no re-set from same head
    rx_push = 1; rx_pe = 1; step();
    chk("pe_n1", {7'b0, lsr[2]}, 8'h00);
    step();
    chk("pe_n2", {6'b0, lsr[7], lsr[2]}, 8'h03);
    lsr_rd = 1; step();
    chk("pe_cleared", {6'b0, lsr[7], lsr[2]}, 8'h00);
    step(); step();
    chk("pe_no_reset", {7'b0, pe}, 8'h00);
    rx_pop = 1; step();

    // errored character behind a clean head
    rx_push = 1; step();
    rx_push = 1; rx_fe = 1; step();
    step();
    chk("fe_not_head", {6'b0, fe, pe}, 8'h00);
    rx_pop = 1; step();
    step();
    chk("fe_at_head", {7'b0, fe}, 8'h01);
    lsr_rd = 1; rx_pop = 1; step();

    // overrun in FIFO mode
    for (int i = 0; i < 16; i++) begin
      rx_push = 1; rx_bi = (i % 4 == 1); step();
    end
    lsr_rd = 1; step();
    e0 = model_errs();
    rx_push = 1; rx_pe = 1; step();
    chk("oe_fifo", {7'b0, lsr[1]}, 8'h01);
    chk("fcnt_full", {3'b0, dut.fcnt_q}, 8'd16);
    chk("err_cnt_kept", {3'b0, dut.err_cnt_q}, 8'(e0));
    lsr_rd = 1; step();
    rx_push = 1; rx_pop = 1; step();
    chk("no_oe_with_pop", {7'b0, lsr[1]}, 8'h00);
    chk("fcnt_still_full", {3'b0, dut.fcnt_q}, 8'd16);

    // overrun in non-FIFO mode
    rx_fifo_clr = 1; step();
    fifo_en = 0; lsr_rd = 1; step();
    rx_push = 1; step();
    rx_push = 1; step();
    chk("oe_nofifo", {7'b0, lsr[1]}, 8'h01);
    chk("below_nofifo", {7'b0, below_level}, 8'h00);

    // trigger thresholds
    rx_fifo_clr = 1; lsr_rd = 1; step();
    fifo_en = 1; ovr_mode = 1;
    rx_trig = 2; rx_count = 7;  #1 chk("trig8_7",   {7'b0, below_level}, 8'h01);
    rx_count = 8;               #1 chk("trig8_8",   {7'b0, below_level}, 8'h00);
    rx_trig = 3; rx_count = 13; #1 chk("trig14_13", {7'b0, below_level}, 8'h01);
    rx_count = 14;              #1 chk("trig14_14", {7'b0, below_level}, 8'h00);
    rx_trig = 1; rx_count = 3;  step();
    rx_trig = 0; rx_count = 0;  step();
    ovr_mode = 0; rx_count = CNT_W'(q.size());
    @(negedge clk);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rx_push = ($urandom_range(0, 99) < 50);
      rx_pe   = ($urandom_range(0, 99) < 20);
      rx_fe   = ($urandom_range(0, 99) < 15);
      rx_bi   = ($urandom_range(0, 99) < 10);
      rx_pop  = ($urandom_range(0, 99) < 35);
      lsr_rd  = ($urandom_range(0, 99) < 15);
      rx_fifo_clr = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 3) fifo_en = ~fifo_en;
      rx_trig = 2'($urandom_range(0, 3));
      tx_count = CNT_W'($urandom_range(0, 2));
      tx_shift_empty = 1'($urandom_range(0, 1));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
